// File: rtl/rec_pkg.sv
// Shared FSM state encoding for the record/playback controller.
package rec_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REC  = ST_REC,
        S_PLAY = ST_PLAY,
        S_STOP = ST_STOP
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Level debouncer: output follows input only after DB_CYCLES stable clks.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level
);

    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (din == level) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= din;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback controller for a sample memory and 2 s timer.
// Define DEBOUNCE_EN to debounce both buttons after synchronization.
module rec_play_ctrl
    import rec_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_rec,
    input  logic              btn_play,
    input  logic              sample_tick,
    input  logic              timer_done,
    output logic              enable_rec,
    output logic              enable_play,
    output logic              timer_clr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] rec_len,
    output logic              fin
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    logic [1:0] rec_sync;
    logic [1:0] play_sync;
    logic       rec_lvl;
    logic       play_lvl;
    logic       rec_prev;
    logic       play_prev;
    logic       rec_press;
    logic       play_press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_sync  <= '0;
            play_sync <= '0;
            rec_prev  <= 1'b0;
            play_prev <= 1'b0;
        end else begin
            rec_sync  <= {rec_sync[0], btn_rec};
            play_sync <= {play_sync[0], btn_play};
            rec_prev  <= rec_lvl;
            play_prev <= play_lvl;
        end
    end

`ifdef DEBOUNCE_EN
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rec (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (rec_sync[1]),
        .level   (rec_lvl)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_play (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (play_sync[1]),
        .level   (play_lvl)
    );
`else
    assign rec_lvl  = rec_sync[1];
    assign play_lvl = play_sync[1];
`endif

    assign rec_press  = rec_lvl & ~rec_prev;
    assign play_press = play_lvl & ~play_prev;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              rec_exit;
    logic              play_exit;

    // cnt is the next address to access; it saturates rather than wraps
    assign cnt_inc = (cnt == ADDR_MAX) ? cnt : cnt + ADDR_W'(1);
    assign cnt_nxt = sample_tick ? cnt_inc : cnt;

    assign rec_exit = timer_done | rec_press |
                      (sample_tick & (cnt == ADDR_MAX));
    assign play_exit = timer_done | play_press |
                       (sample_tick & (cnt_inc == rec_len));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_addr    <= '0;
            rec_len     <= '0;
            enable_rec  <= 1'b0;
            enable_play <= 1'b0;
            timer_clr   <= 1'b0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            fin         <= 1'b0;
        end else begin
            timer_clr <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            fin       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rec_press) begin
                        state      <= S_REC;
                        enable_rec <= 1'b1;
                        timer_clr  <= 1'b1;
                        cnt        <= '0;
                        mem_addr   <= '0;
                    end else if (play_press && rec_len != '0) begin
                        state       <= S_PLAY;
                        enable_play <= 1'b1;
                        timer_clr   <= 1'b1;
                        cnt         <= '0;
                        mem_addr    <= '0;
                    end
                end
                S_REC: begin
                    if (sample_tick) begin
                        mem_we   <= 1'b1;
                        mem_addr <= cnt;
                        cnt      <= cnt_inc;
                    end
                    if (rec_exit) begin
                        state      <= S_STOP;
                        enable_rec <= 1'b0;
                        fin        <= 1'b1;
                        rec_len    <= cnt_nxt;
                    end
                end
                S_PLAY: begin
                    if (sample_tick) begin
                        mem_re   <= 1'b1;
                        mem_addr <= cnt;
                        cnt      <= cnt_inc;
                    end
                    if (play_exit) begin
                        state       <= S_STOP;
                        enable_play <= 1'b0;
                        fin         <= 1'b1;
                    end
                end
                S_STOP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
